rcas_rr_sched: RTL and testbench
================================

Name: rcas_rr_sched

Overview:
Round-robin scheduler that shares one G-bit ripple-carry adder/subtractor datapath between two requesters. Each requester presents an operation (add or subtract) over a valid/ready channel. The block arbitrates, latches operands, drives the shared datapath and returns the tagged result on a single response channel with backpressure. It instantiates the adder/subtractor internally and is the only driver of its inputs.

Parameters:
G, 32, operand and result width in bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous, active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  G  requester 0 operand A
req0_b  input  G  requester 0 operand B
req0_mode  input  1  requester 0 operation: 0 add, 1 subtract
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  G  requester 1 operand A
req1_b  input  G  requester 1 operand B
req1_mode  input  1  requester 1 operation: 0 add, 1 subtract
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_id  output  1  requester that owns the result
rsp_mode  output  1  operation that produced the result
rsp_sum  output  G  sum or difference
rsp_carry  output  1  add: carry out; subtract: 1 = no borrow (A >= B unsigned)
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low at a clk edge) sets state IDLE, ptr=0, rsp_valid=0, rsp_id=0, rsp_mode=0, rsp_sum=0, rsp_carry=0, busy=0. req0_ready and req1_ready are 0 while rst_n is low.
- Reset wins over everything at that edge. An in-flight operation is discarded with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant is combinational from the valids and ptr.
  - Only req0_valid high: grant 0. Only req1_valid high: grant 1.
  - Both high: grant = ptr.
  - reqN_ready = (state==IDLE) & grant==N & reqN_valid. Ready is never asserted outside IDLE.
  - On handshake: latch a, b, mode and id into operand registers, then go to EXEC.
- EXEC (1 cycle): datapath inputs are latched_a, latched_b, mode=latched_mode, cin=latched_mode.
  - Datapath computes A+B when mode=0, A+~B+1 when mode=1.
  - At the end of EXEC, capture sum, carry, id and mode into the rsp_* registers, set rsp_valid=1 and go to RESP.
- RESP: rsp_valid and all rsp_* fields are held stable until rsp_ready is high at a clk edge.
  - On that edge: rsp_valid=0, ptr = ~rsp_id, state IDLE.
  - rsp_* data fields keep their last value after rsp_valid drops.
- Latency: handshake at edge T gives rsp_valid high after edge T+1. With rsp_ready held high, rsp_valid is high for exactly one cycle.
- Throughput: at most one operation per 3 cycles. No new request is accepted until the response has been consumed.
- Arithmetic is modulo 2^G, unsigned. There is no separate overflow flag.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- ptr changes only on response completion, never on a handshake alone.
- A valid deasserted before its handshake has no effect and is not remembered.
- Operand inputs are sampled only at the handshake edge. Later changes are ignored.
- Backpressure: rsp_ready low holds the block in RESP indefinitely. Both readys stay 0 during that time.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both valids high → all outputs 0, no ready asserted. Release → req0_ready=1 first cycle (ptr=0).
- Single add: req0 a=0xFFFFFFFF b=1 mode=0, rsp_ready=1 → rsp_valid one cycle after the handshake cycle, rsp_id=0 sum=0 carry=1.
- Subtract, both borrow cases (a=7 b=5, then a=5 b=7):
  - req1 a=7 b=5 mode=1 → sum=2 carry=1.
  - req1 a=5 b=7 mode=1 → sum=0xFFFFFFFE carry=0.
- Contention: both valid continuously for 4 operations, rsp_ready=1 → rsp_id sequence 0,1,0,1. No ready asserted while busy=1.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid rises while changing req operands → rsp_* stable, no readys. Raise rsp_ready → rsp_valid drops next edge and the other requester is granted.
- Reset mid-operation: assert rst_n=0 during EXEC → no response is produced, ptr=0. After release, a pending req1 alone is granted normally.

Source files
------------

// File: rtl/rcas_rr_sched.sv
// Round-robin scheduler sharing one ripple-carry adder/subtractor between two
// requesters, with a tagged, backpressured response channel.

module rcas_addsub #(
  parameter int G = 32
) (
  input  logic [G-1:0] a,
  input  logic [G-1:0] b,
  input  logic         mode,
  input  logic         cin,
  output logic [G-1:0] sum,
  output logic         cout
);
  logic [G:0]   c;
  logic [G-1:0] b_eff;

  assign b_eff = mode ? ~b : b;
  assign c[0]  = cin;

  genvar i;
  generate
    for (i = 0; i < G; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b_eff[i] ^ c[i];
      assign c[i+1]   = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
    end
  endgenerate

  assign cout = c[G];
endmodule

// state | meaning
// IDLE  | arbitrating, ready may be asserted to the granted requester
// EXEC  | latched operands driven through the shared adder/subtractor
// RESP  | result held on rsp_* until the consumer takes it
module rcas_rr_sched #(
  parameter int G = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [G-1:0] req0_a,
  input  logic [G-1:0] req0_b,
  input  logic         req0_mode,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [G-1:0] req1_a,
  input  logic [G-1:0] req1_b,
  input  logic         req1_mode,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic         rsp_mode,
  output logic [G-1:0] rsp_sum,
  output logic         rsp_carry,
  output logic         busy
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic [G-1:0] op_a_q, op_a_d;
  logic [G-1:0] op_b_q, op_b_d;
  logic         op_mode_q, op_mode_d;
  logic         op_id_q, op_id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic         rsp_mode_q, rsp_mode_d;
  logic [G-1:0] rsp_sum_q, rsp_sum_d;
  logic         rsp_carry_q, rsp_carry_d;

  logic         grant;
  logic [G-1:0] dp_sum;
  logic         dp_cout;

  rcas_addsub #(.G(G)) u_addsub (
    .a    (op_a_q),
    .b    (op_b_q),
    .mode (op_mode_q),
    .cin  (op_mode_q),
    .sum  (dp_sum),
    .cout (dp_cout)
  );

  always_comb begin
    grant = ptr_q;
    if (req0_valid && !req1_valid) grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
  end

  // Ready is gated by rst_n so nothing handshakes during a reset cycle.
  assign req0_ready = rst_n && (state_q == ST_IDLE) && !grant && req0_valid;
  assign req1_ready = rst_n && (state_q == ST_IDLE) &&  grant && req1_valid;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_mode_d   = op_mode_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_mode_d  = rsp_mode_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_ready || req1_ready) begin
          op_a_d    = grant ? req1_a    : req0_a;
          op_b_d    = grant ? req1_b    : req0_b;
          op_mode_d = grant ? req1_mode : req0_mode;
          op_id_d   = grant;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_sum_d   = dp_sum;
        rsp_carry_d = dp_cout;
        rsp_id_d    = op_id_q;
        rsp_mode_d  = op_mode_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = ~rsp_id_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_mode_q   <= 1'b0;
      op_id_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_mode_q  <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_mode_q   <= op_mode_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_mode_q  <= rsp_mode_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_mode  = rsp_mode_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_rcas_rr_sched.sv
// Directed bench for rcas_rr_sched: reset, add/subtract results, arbitration
// order, backpressure and reset during an operation.

module tb_rcas_rr_sched;
  localparam int G = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_mode;
  logic [G-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_mode;
  logic [G-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_mode, rsp_carry, busy;
  logic [G-1:0] rsp_sum;

  int checks   = 0;
  int failures = 0;

  rcas_rr_sched #(.G(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_mode  (req1_mode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_mode   (rsp_mode),
    .rsp_sum    (rsp_sum),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [G-1:0] obs, input logic [G-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_id;
    rst_n      = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h1111_1111; req0_b = 32'h2222_2222; req0_mode = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h3333_3333; req1_b = 32'h4444_4444; req1_mode = 1'b1;
    rsp_ready  = 1'b0;
    repeat (3) step();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_id",    {31'd0, rsp_id},    0);
    chk("rst_rsp_mode",  {31'd0, rsp_mode},  0);
    chk("rst_rsp_sum",   rsp_sum,            0);
    chk("rst_rsp_carry", {31'd0, rsp_carry}, 0);
    chk("rst_busy",      {31'd0, busy},      0);
    chk("rst_req0_rdy",  {31'd0, req0_ready}, 0);
    chk("rst_req1_rdy",  {31'd0, req1_ready}, 0);

    // Release reset with both valid: ptr=0 grants requester 0.
    rst_n = 1'b1;
    req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_mode = 1'b0;
    #1;
    chk("rel_req0_rdy", {31'd0, req0_ready}, 1);
    chk("rel_req1_rdy", {31'd0, req1_ready}, 0);
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    step();
    req0_valid = 1'b0;
    chk("add_exec_busy",  {31'd0, busy},      1);
    chk("add_exec_valid", {31'd0, rsp_valid}, 0);
    chk("add_exec_rdy0",  {31'd0, req0_ready}, 0);
    step();
    chk("add_valid", {31'd0, rsp_valid}, 1);
    chk("add_id",    {31'd0, rsp_id},    0);
    chk("add_mode",  {31'd0, rsp_mode},  0);
    chk("add_sum",   rsp_sum,            32'h0000_0000);
    chk("add_carry", {31'd0, rsp_carry}, 1);
    step();
    chk("add_done_valid", {31'd0, rsp_valid}, 0);
    chk("add_done_busy",  {31'd0, busy},      0);

    // Subtract without borrow.
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd5; req1_mode = 1'b1;
    #1;
    chk("sub1_rdy1", {31'd0, req1_ready}, 1);
    step();
    req1_valid = 1'b0;
    step();
    chk("sub1_valid", {31'd0, rsp_valid}, 1);
    chk("sub1_id",    {31'd0, rsp_id},    1);
    chk("sub1_mode",  {31'd0, rsp_mode},  1);
    chk("sub1_sum",   rsp_sum,            32'd2);
    chk("sub1_carry", {31'd0, rsp_carry}, 1);
    step();

    // Subtract with borrow.
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd7; req1_mode = 1'b1;
    #1;
    chk("sub2_rdy1", {31'd0, req1_ready}, 1);
    step();
    req1_valid = 1'b0;
    step();
    chk("sub2_sum",   rsp_sum,            32'hFFFF_FFFE);
    chk("sub2_carry", {31'd0, rsp_carry}, 0);
    step();

    // Contention: ptr is 0 after the last response from requester 1.
    req0_valid = 1'b1; req0_a = 32'd10;  req0_b = 32'd3; req0_mode = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd1; req1_mode = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 1);
      chk("cont_rdy0", {31'd0, req0_ready}, {31'd0, ~exp_id});
      chk("cont_rdy1", {31'd0, req1_ready}, {31'd0, exp_id});
      step();
      chk("cont_exec_rdy", {30'd0, req0_ready, req1_ready}, 0);
      step();
      chk("cont_busy_rdy", {30'd0, req0_ready, req1_ready}, 0);
      chk("cont_id",  {31'd0, rsp_id}, {31'd0, exp_id});
      chk("cont_sum", rsp_sum, exp_id ? 32'd99 : 32'd13);
      step();
    end

    // Backpressure on a requester-0 result while operands keep changing.
    rsp_ready = 1'b0;
    chk("bp_rdy0", {31'd0, req0_ready}, 1);
    step();
    req0_a = 32'd55;
    step();
    chk("bp_valid", {31'd0, rsp_valid}, 1);
    for (int k = 0; k < 10; k++) begin
      req0_a = 32'(k + 200);
      req1_a = 32'(k * 3);
      req1_b = 32'(k);
      step();
      chk("bp_hold_valid", {31'd0, rsp_valid}, 1);
      chk("bp_hold_sum",   rsp_sum,            32'd13);
      chk("bp_hold_id",    {31'd0, rsp_id},    0);
      chk("bp_hold_rdy",   {30'd0, req0_ready, req1_ready}, 0);
    end
    req1_a = 32'd100; req1_b = 32'd1;
    rsp_ready = 1'b1;
    step();
    chk("bp_drop_valid", {31'd0, rsp_valid}, 0);
    chk("bp_keep_sum",   rsp_sum,            32'd13);
    chk("bp_next_rdy0",  {31'd0, req0_ready}, 0);
    chk("bp_next_rdy1",  {31'd0, req1_ready}, 1);

    // Reset while requester 1 is in EXEC: result must be discarded.
    step();
    chk("mid_exec_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", {31'd0, rsp_valid}, 0);
    chk("mid_rst_busy",  {31'd0, busy},      0);
    chk("mid_rst_sum",   rsp_sum,            0);
    rst_n = 1'b1;
    #1;
    chk("mid_ptr0_rdy0", {31'd0, req0_ready}, 1);
    chk("mid_ptr0_rdy1", {31'd0, req1_ready}, 0);
    req0_valid = 1'b0;
    #1;
    chk("mid_req1_rdy", {31'd0, req1_ready}, 1);
    step();
    req1_valid = 1'b0;
    chk("mid_exec_valid", {31'd0, rsp_valid}, 0);
    step();
    chk("mid_valid", {31'd0, rsp_valid}, 1);
    chk("mid_id",    {31'd0, rsp_id},    1);
    chk("mid_sum",   rsp_sum,            32'd99);
    step();
    chk("mid_done",  {31'd0, rsp_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
